// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl
// Purpose  : Sequencing controller for a direct-mapped, one-word-per-line
//            data cache between the pipeline memory stage and main memory.
//            Owns the valid/tag/data arrays and does the hit/miss compare.
//            A read miss stalls the pipeline, fetches the word over a req/ack
//            handshake and fills the line. A store is always written through
//            to memory; the line is updated only if it already hits (there is
//            no write-allocate).
// Ports    : clk, rst         - clock, synchronous active-high reset
//            cpu_re_i/we_i    - load/store request, held while stall_o=1
//            cpu_addr_i       - byte address (bits [1:0] ignored)
//            cpu_wdata_i      - store data
//            cpu_rdata_o      - load data (valid when cpu_re_i=1, stall_o=0)
//            stall_o          - combinational pipeline freeze
//            mem_req_o/we_o   - registered memory request / write strobe
//            mem_addr_o       - word-aligned memory address
//            mem_wdata_o      - memory write data
//            mem_rdata_i      - memory read data, valid with mem_ack_i
//            mem_ack_i        - one-cycle completion strobe
//            hit_count_o      - read hits since reset (wraps)
//            miss_count_o     - read misses since reset (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module cache_ctrl #(
    parameter int ADDRESS_WIDTH = 3,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_re_i,
    input  logic                  cpu_we_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
);

    localparam int LINES = 2 ** ADDRESS_WIDTH;
    localparam int TAG_W = 32 - ADDRESS_WIDTH - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [DATA_WIDTH-1:0]   data_q [LINES];
    logic                    mem_req_q, mem_we_q, is_load_q;
    logic [31:0]             mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, resp_q;
    logic [31:0]             hit_cnt_q, miss_cnt_q;

    logic [ADDRESS_WIDTH-1:0] w_req_idx, w_lat_idx;
    logic [TAG_W-1:0]         w_req_tag, w_lat_tag;
    logic                     w_req_hit, w_lat_hit;
    logic                     w_start_rd, w_start_wr, w_rd_hit, w_done;
    logic [31:0]              w_aligned;
    logic                     w_unused;

    // The latched request address lives in mem_addr_q; it is only reloaded on
    // entry to a memory state, so it stays valid through RESP.
    assign w_req_idx = cpu_addr_i[ADDRESS_WIDTH+1:2];
    assign w_req_tag = cpu_addr_i[31:ADDRESS_WIDTH+2];
    assign w_lat_idx = mem_addr_q[ADDRESS_WIDTH+1:2];
    assign w_lat_tag = mem_addr_q[31:ADDRESS_WIDTH+2];
    assign w_req_hit = valid_q[w_req_idx] && (tag_q[w_req_idx] == w_req_tag);
    assign w_lat_hit = valid_q[w_lat_idx] && (tag_q[w_lat_idx] == w_lat_tag);
    assign w_aligned = {cpu_addr_i[31:2], 2'b00};
    assign w_done    = mem_ack_i && (state_q == RD_MISS || state_q == WR_THRU);
    assign w_unused  = ^cpu_addr_i[1:0];

    always_comb begin
        state_d     = state_q;
        stall_o     = 1'b0;
        cpu_rdata_o = '0;
        w_start_rd  = 1'b0;
        w_start_wr  = 1'b0;
        w_rd_hit    = 1'b0;
        case (state_q)
            IDLE: begin
                // A store wins over a simultaneous load; the load is dropped.
                if (cpu_we_i) begin
                    stall_o    = 1'b1;
                    w_start_wr = 1'b1;
                    state_d    = WR_THRU;
                end else if (cpu_re_i) begin
                    if (w_req_hit) begin
                        cpu_rdata_o = data_q[w_req_idx];
                        w_rd_hit    = 1'b1;
                    end else begin
                        stall_o    = 1'b1;
                        w_start_rd = 1'b1;
                        state_d    = RD_MISS;
                    end
                end
            end
            RD_MISS, WR_THRU: begin
                stall_o = 1'b1;
                if (mem_ack_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (is_load_q) begin
                    cpu_rdata_o = resp_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            resp_q      <= '0;
            is_load_q   <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (w_start_rd) begin
                mem_addr_q <= w_aligned;
                mem_req_q  <= 1'b1;
                mem_we_q   <= 1'b0;
                is_load_q  <= 1'b1;
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
            if (w_start_wr) begin
                mem_addr_q  <= w_aligned;
                mem_wdata_q <= cpu_wdata_i;
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b1;
                is_load_q   <= 1'b0;
            end
            if (w_rd_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (w_done) begin
                mem_req_q <= 1'b0;
                mem_we_q  <= 1'b0;
                if (state_q == RD_MISS) begin
                    valid_q[w_lat_idx] <= 1'b1;
                    resp_q             <= mem_rdata_i;
                end
            end
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (!rst && w_done) begin
            if (state_q == RD_MISS) begin
                tag_q[w_lat_idx]  <= w_lat_tag;
                data_q[w_lat_idx] <= mem_rdata_i;
            end else if (w_lat_hit) begin
                data_q[w_lat_idx] <= mem_wdata_q;
            end
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;

endmodule
`default_nettype wire

// File: doc/cache_ctrl.md
# cache_ctrl

Sequencing controller for the CPU's direct-mapped, one-word-per-line data cache. It sits between the memory stage of the pipeline and the main data memory. It owns the tag/valid/data arrays and performs the hit/miss compare. On a miss it stalls the pipeline, fetches the word over a req/ack memory handshake and fills the line. Stores are written through to memory, updating the cache line on a hit.

## Interface
- ADDRESS_WIDTH, 3: index bits; number of lines = 2**ADDRESS_WIDTH
- DATA_WIDTH, 32: data word width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_re  in  1  load request; held by CPU while stall=1
- cpu_we  in  1  store request; held by CPU while stall=1
- cpu_addr  in  32  byte address; index = addr[ADDRESS_WIDTH+1:2], tag = addr[31:ADDRESS_WIDTH+2], addr[1:0] ignored
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_rdata  out  DATA_WIDTH  load data; valid when cpu_re=1 and stall=0
- stall  out  1  freeze pipeline (combinational)
- mem_req  out  1  memory request (registered)
- mem_we  out  1  1 = memory write, 0 = memory read
- mem_addr  out  32  word-aligned address (addr[1:0]=0)
- mem_wdata  out  DATA_WIDTH  write data
- mem_rdata  in  DATA_WIDTH  read data, valid in the mem_ack cycle
- mem_ack  in  1  one-cycle completion strobe
- hit_count  out  32  read hits since reset, wraps at 2**32
- miss_count  out  32  read misses since reset, wraps at 2**32

## Operation
- Per line: valid bit, tag of (32-ADDRESS_WIDTH-2) bits, data word. hit = valid & (stored tag == request tag).
- FSM states: IDLE, RD_MISS, WR_THRU, RESP.
- IDLE, cpu_we=1: stall=1. Latch addr and wdata. Go to WR_THRU. cpu_we has priority if cpu_re is also 1; the load is ignored.
- IDLE, cpu_re=1 and hit: stall=0, cpu_rdata = line data, hit_count+1. Stay in IDLE.
- IDLE, cpu_re=1 and miss: stall=1, latch addr, miss_count+1. Go to RD_MISS.
- IDLE, no request: stall=0.
- RD_MISS: mem_req=1, mem_we=0, mem_addr = latched address. On mem_ack: write line (data=mem_rdata, tag, valid=1), latch mem_rdata into resp register, go to RESP.
- WR_THRU: mem_req=1, mem_we=1, mem_addr/mem_wdata from latches. On mem_ack: if the latched address hits, update line data; otherwise the array is unchanged (no write-allocate). Go to RESP.
- RESP: stall=0. For a load, cpu_rdata = resp register. Next state is IDLE unconditionally; no request is accepted in RESP.
- stall=1 in RD_MISS and WR_THRU.
- mem_ack is ignored in IDLE and RESP.
- Request lines change only on state entry. They are held stable until ack.

## Timing
- Reset values:
  - state=IDLE, all valid=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - hit_count=0, miss_count=0, stall=0, cpu_rdata=0 while idle
  - Tag/data arrays need not be reset.
- Read hit: 0-cycle latency, data in the same cycle as the request.
- Read miss, ack k cycles after mem_req rises (k≥0):
  - c0: IDLE, stall=1
  - c1: mem_req=1
  - c1+k: mem_ack
  - c2+k: RESP, stall=0, data valid
  - c3+k: IDLE
- Store: same sequence as a read miss. stall is low only in RESP.
- mem_req falls in the cycle after mem_ack.
- Reset asserted mid-miss or mid-write: the next edge returns to IDLE and clears mem_req and valid bits. The pending memory transaction is abandoned.
- Counters increment once per accepted IDLE load, never during a held stalled request.

## Test plan
- After reset, load 0x0000_0010 (idx 4) with mem returning 0xDEAD_BEEF, ack k=2: stall high 4 cycles, RESP shows 0xDEAD_BEEF, miss_count=1. Reloading 0x10 hits same cycle, stall=0, hit_count=1.
- Conflict: fill 0x10, then load 0x30 (same idx 4, different tag): miss, mem_addr=0x30. Then 0x10 misses again; miss_count=3.
- Store hit: 0x10 cached, store 0x1234_5678, ack k=0: mem_req/mem_we high 1 cycle with mem_wdata=0x1234_5678. Next load of 0x10 hits, returns 0x1234_5678.
- Store miss to 0x44: memory write issued. Subsequent load of 0x44 misses (no write-allocate).
- cpu_re=cpu_we=1 on 0x8: only a write is issued (mem_we=1), hit/miss counters unchanged. Spurious mem_ack in IDLE has no effect.
- rst pulsed during RD_MISS before ack: mem_req=0 next cycle, state IDLE. Load of a previously cached address now misses.
